data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameters SHALL be:
- DEPTH, 32, number of 64-bit doublewords stored.
- WAIT_CYCLES, 2, extra wait cycles before a response (0..15).

REQ-002 Ports SHALL be, clock and reset first:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low.
- req_valid  in  1  access request present.
- req_ready  out  1  responder accepts a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  64  byte address.
- req_wdata  in  64  store data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  pipeline accepts the response.
- rsp_rdata  out  64  load data.
- rsp_err  out  1  misaligned or out-of-range access.
- busy  out  1  transaction in flight; pipeline stall source.
- element1..element8  out  64 each  continuous view of mem[0]..mem[7].

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, WAIT and RESP.
REQ-004 req_ready SHALL be 1 only in IDLE, and busy SHALL equal (state != IDLE).
REQ-005 On accept (req_valid && req_ready at an edge), the block SHALL capture req_we, req_addr and req_wdata. It SHALL go to WAIT if WAIT_CYCLES > 0, otherwise straight to RESP.
REQ-006 WAIT SHALL count WAIT_CYCLES cycles and then enter RESP. rsp_valid SHALL first be high WAIT_CYCLES+1 cycles after the accepting edge.
REQ-007 The word index SHALL be req_addr[3 +: clog2(DEPTH)].
- Error when req_addr[2:0] != 0, or when req_addr >> 3 >= DEPTH.
REQ-008 The store write and the load read SHALL both occur on the edge that enters RESP.
- Error: rsp_err = 1, rsp_rdata = 0, memory unchanged.
- Store: rsp_rdata = 0.
REQ-009 rsp_valid, rsp_rdata and rsp_err SHALL be held stable in RESP until rsp_ready = 1. The state SHALL then return to IDLE on that edge.
REQ-010 req_ready SHALL stay low during the handshake cycle. Back-to-back accepts are therefore separated by at least one IDLE cycle.
REQ-011 element1..element8 SHALL reflect a committed store on the cycle after the commit edge.
REQ-012 Requests presented while not ready SHALL be ignored, not queued.

Reset
REQ-013 While reset = 0, regardless of clk:
- state = IDLE, wait counter = 0.
- rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, busy = 0.
- Memory is initialised per REQ-016.
REQ-014 Reset asserted mid-transaction SHALL drop the captured request, including an uncommitted store.
REQ-015 req_ready SHALL be 1 on the first cycle after reset deasserts.

Configuration
REQ-016 The macro DMEM_INIT_EN SHALL select the reset contents of memory:
- Defined: mem[0..7] = 9, 3, 7, 1, 8, 2, 6, 4 (the sort test vector), all other words 0.
- Undefined: all words reset to 0.

Structure
REQ-017 Package dmem_pkg SHALL hold:
- the state enum typedef;
- the DMEM_INIT_VEC constant array of 8 x 64-bit values;
- the default DEPTH and WAIT_CYCLES constants.
REQ-018 Storage and the element taps SHALL be in sub-module dmem_array. The FSM and the wait counter stay in data_mem_responder.

Verification
REQ-019 Bench SHALL cover these directed scenarios:
- Reset with DMEM_INIT_EN defined -> element1..8 = 9, 3, 7, 1, 8, 2, 6, 4; req_ready = 1; busy = 0.
- Store 0x55 at addr 0x18, WAIT_CYCLES = 2 -> rsp_valid high 3 cycles after accept, rsp_err = 0; element4 = 0x55 on the following cycle.
- Load addr 0x08 after reset with init -> rsp_rdata = 3; busy high from the cycle after accept until the handshake.
- Load addr 0x0C (misaligned) and addr 0x100 (out of range) -> rsp_err = 1, rsp_rdata = 0, memory unchanged.
- rsp_ready held low for 5 cycles -> rsp_valid and rsp_rdata stable throughout; req_ready = 0 throughout.
- Reset pulsed low during WAIT of a store to 0x00 -> FSM returns to IDLE; element1 keeps its reset value.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg
// Shared definitions for the data memory responder:
//   - dmem_state_t   : responder FSM states (IDLE, WAIT, RESP)
//   - DMEM_INIT_VEC  : reset contents of words 0..7 when DMEM_INIT_EN is defined
//   - DMEM_DEPTH     : default number of 64-bit doublewords
//   - DMEM_WAIT_CYCLES : default extra wait cycles before a response
package dmem_pkg;

    localparam int DMEM_DEPTH       = 32;
    localparam int DMEM_WAIT_CYCLES = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    // The sort test vector preloaded into the first eight words
    localparam logic [63:0] DMEM_INIT_VEC [8] = '{
        64'd9, 64'd3, 64'd7, 64'd1, 64'd8, 64'd2, 64'd6, 64'd4
    };

endpackage

// File: rtl/dmem_array.sv
// dmem_array
// Doubleword storage with one combinational read port, one synchronous write
// port and a continuous view of words 0..7.
// Configuration macro: DMEM_INIT_EN -- when defined, words 0..7 reset to
// DMEM_INIT_VEC; otherwise every word resets to zero.
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-low reset
//   wr_en, addr, wdata  write port (word index)
//   rdata               combinational read of mem[addr]
//   element1..element8  mem[0]..mem[7]
// DEPTH must be at least 8 so the element taps exist.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = DMEM_DEPTH,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] addr,
    input  logic [63:0]   wdata,
    output logic [63:0]   rdata,
    output logic [63:0]   element1,
    output logic [63:0]   element2,
    output logic [63:0]   element3,
    output logic [63:0]   element4,
    output logic [63:0]   element5,
    output logic [63:0]   element6,
    output logic [63:0]   element7,
    output logic [63:0]   element8
);

    logic [63:0] mem [DEPTH];

    // Storage: cleared on reset (optionally preloaded with the sort vector),
    // written only when the responder commits a legal store.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
`ifdef DMEM_INIT_EN
            for (int i = 0; i < 8 && i < DEPTH; i++) begin
                mem[i] <= DMEM_INIT_VEC[i];
            end
`endif
        end else if (wr_en) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata    = mem[addr];
    assign element1 = mem[0];
    assign element2 = mem[1];
    assign element3 = mem[2];
    assign element4 = mem[3];
    assign element5 = mem[4];
    assign element6 = mem[5];
    assign element7 = mem[6];
    assign element8 = mem[7];

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder
// Single-outstanding data memory responder with a fixed wait latency.
// A request is accepted in IDLE, waits WAIT_CYCLES cycles, then the store or
// load is performed on the edge entering RESP, and the response is held until
// the pipeline takes it.
// Configuration macro: DMEM_INIT_EN (reset contents, see dmem_array).
// Ports:
//   clk, reset                      clock, asynchronous active-low reset
//   req_valid/req_ready             request handshake
//   req_we, req_addr, req_wdata     1 = store; byte address; store data
//   rsp_valid/rsp_ready             response handshake
//   rsp_rdata, rsp_err              load data; misaligned/out-of-range flag
//   busy                            transaction in flight
//   element1..element8              continuous view of mem[0]..mem[7]
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH       = DMEM_DEPTH,
    parameter int WAIT_CYCLES = DMEM_WAIT_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic [63:0] element1,
    output logic [63:0] element2,
    output logic [63:0] element3,
    output logic [63:0] element4,
    output logic [63:0] element5,
    output logic [63:0] element6,
    output logic [63:0] element7,
    output logic [63:0] element8
);

    localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] LAST_WAIT = 4'(WAIT_CYCLES - 1);

    dmem_state_t   state;
    logic [3:0]    wait_cnt;
    logic          cap_we;
    logic [63:0]   cap_addr;
    logic [63:0]   cap_wdata;

    logic          accept;
    logic          op_we;
    logic [63:0]   op_addr;
    logic [63:0]   op_wdata;
    logic          op_err;
    logic [AW-1:0] op_idx;
    logic          enter_resp;
    logic          mem_we;
    logic [63:0]   mem_rdata;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign rsp_valid = (state == RESP);

    // With zero wait cycles RESP is entered on the accepting edge itself,
    // before the capture registers hold the request, so the operands come
    // straight from the request bus while in IDLE.
    always_comb begin
        accept   = req_valid && req_ready;
        op_we    = cap_we;
        op_addr  = cap_addr;
        op_wdata = cap_wdata;
        if (state == IDLE) begin
            op_we    = req_we;
            op_addr  = req_addr;
            op_wdata = req_wdata;
        end
        op_err     = (op_addr[2:0] != 3'b000) || (op_addr[63:3] >= 61'(DEPTH));
        op_idx     = op_addr[3 +: AW];
        enter_resp = ((state == IDLE) && accept && (WAIT_CYCLES == 0)) ||
                     ((state == WAIT) && (wait_cnt == LAST_WAIT));
        mem_we     = enter_resp && op_we && !op_err;
    end

    // FSM, wait counter, request capture and response registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cap_we    <= req_we;
                        cap_addr  <= req_addr;
                        cap_wdata <= req_wdata;
                        wait_cnt  <= '0;
                        state     <= (WAIT_CYCLES == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == LAST_WAIT) begin
                        state <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            // Stores and errors return zero data; only legal loads return memory.
            if (enter_resp) begin
                rsp_err   <= op_err;
                rsp_rdata <= (op_we || op_err) ? 64'd0 : mem_rdata;
            end
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (mem_we),
        .addr     (op_idx),
        .wdata    (op_wdata),
        .rdata    (mem_rdata),
        .element1 (element1),
        .element2 (element2),
        .element3 (element3),
        .element4 (element4),
        .element5 (element5),
        .element6 (element6),
        .element7 (element7),
        .element8 (element8)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
// Scoreboard bench for data_mem_responder: each request pushes its expected
// response (from a small memory model) onto a queue, which is popped and
// compared when the responder raises rsp_valid. Works with or without
// DMEM_INIT_EN; the model follows the same macro.
module tb_data_mem_responder;

    localparam int DEPTH       = 32;
    localparam int WAIT_CYCLES = 2;
    localparam int AW          = 5;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic [63:0] element1, element2, element3, element4;
    logic [63:0] element5, element6, element7, element8;
    logic [63:0] elems [8];

    logic [63:0] model_mem [DEPTH];
    exp_t        sb_q [$];
    int          assert_count;
    int          fail_count;

    data_mem_responder #(
        .DEPTH       (DEPTH),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .element1  (element1),
        .element2  (element2),
        .element3  (element3),
        .element4  (element4),
        .element5  (element5),
        .element6  (element6),
        .element7  (element7),
        .element8  (element8)
    );

    assign elems[0] = element1;
    assign elems[1] = element2;
    assign elems[2] = element3;
    assign elems[3] = element4;
    assign elems[4] = element5;
    assign elems[5] = element6;
    assign elems[6] = element7;
    assign elems[7] = element8;

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something wedges outside the bounded waits
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic resetModel();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 64'd0;
`ifdef DMEM_INIT_EN
        model_mem[0] = 64'd9;
        model_mem[1] = 64'd3;
        model_mem[2] = 64'd7;
        model_mem[3] = 64'd1;
        model_mem[4] = 64'd8;
        model_mem[5] = 64'd2;
        model_mem[6] = 64'd6;
        model_mem[7] = 64'd4;
`endif
    endtask

    task automatic checkElements(input string tag);
        for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("%s_element%0d", tag, k + 1), elems[k], model_mem[k]);
        end
    endtask

    // Drive one request, update the model and push the expected response.
    // Returns #1 after the accepting edge.
    task automatic applyStimulus(input logic we, input logic [63:0] addr,
                                 input logic [63:0] wdata);
        exp_t e;
        int   n;
        logic aerr;
        aerr    = (addr[2:0] != 3'b000) || ((addr >> 3) >= 64'(DEPTH));
        e.err   = aerr;
        e.rdata = 64'd0;
        if (!aerr) begin
            if (we) model_mem[addr[3 +: AW]] = wdata;
            else    e.rdata = model_mem[addr[3 +: AW]];
        end
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) checkOutput("req_ready_timeout", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Wait for the response, compare it against the scoreboard, optionally
    // stall rsp_ready for 'hold' cycles (with an ignored request poked in),
    // then complete the handshake.
    task automatic collectResponse(input int hold, input logic poke);
        exp_t e;
        int   lat;
        checkOutput("busy_after_accept", {63'd0, busy}, 64'd1);
        checkOutput("req_ready_after_accept", {63'd0, req_ready}, 64'd0);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!rsp_valid) checkOutput("busy_in_wait", {63'd0, busy}, 64'd1);
        end while (!rsp_valid && lat < 40);
        // Sampled just before edge 'lat' after the accepting edge
        checkOutput("rsp_latency", 64'(lat), 64'(WAIT_CYCLES + 1));
        checkElements("post_commit");
        e = sb_q.pop_front();
        checkOutput("rsp_rdata", rsp_rdata, e.rdata);
        checkOutput("rsp_err", {63'd0, rsp_err}, {63'd0, e.err});
        for (int c = 0; c < hold; c++) begin
            if (poke && c == 0) begin
                req_valid = 1'b1;
                req_we    = 1'b1;
                req_addr  = 64'h10;
                req_wdata = 64'hBAD;
            end
            @(negedge clk);
            checkOutput("hold_rsp_valid", {63'd0, rsp_valid}, 64'd1);
            checkOutput("hold_rsp_rdata", rsp_rdata, e.rdata);
            checkOutput("hold_req_ready", {63'd0, req_ready}, 64'd0);
        end
        rsp_ready = 1'b1;
        #1;
        checkOutput("req_ready_handshake", {63'd0, req_ready}, 64'd0);
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        checkOutput("rsp_valid_after_hs", {63'd0, rsp_valid}, 64'd0);
        checkOutput("busy_after_hs", {63'd0, busy}, 64'd0);
        checkOutput("req_ready_after_hs", {63'd0, req_ready}, 64'd1);
    endtask

    task automatic transact(input logic we, input logic [63:0] addr,
                            input logic [63:0] wdata);
        applyStimulus(we, addr, wdata);
        collectResponse(0, 1'b0);
    endtask

    initial begin
        assert_count = 0;
        fail_count   = 0;
        reset        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        rsp_ready    = 1'b0;
        resetModel();

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        checkOutput("rst_rsp_rdata", rsp_rdata, 64'd0);
        checkOutput("rst_rsp_err", {63'd0, rsp_err}, 64'd0);
        checkOutput("rst_busy", {63'd0, busy}, 64'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_req_ready", {63'd0, req_ready}, 64'd1);
        checkElements("reset");

        // Load word 1 (3 with the init vector)
        transact(1'b0, 64'h08, 64'd0);

        // Store 0x55 at word 3, then read it back
        applyStimulus(1'b1, 64'h18, 64'h55);
        collectResponse(0, 1'b0);
        checkOutput("store_element4", element4, 64'h55);
        transact(1'b0, 64'h18, 64'd0);

        // Error cases: misaligned, first out-of-range word, huge address, bad store
        transact(1'b0, 64'h0C, 64'd0);
        transact(1'b0, 64'h100, 64'd0);
        transact(1'b0, 64'h8000_0000_0000_0000, 64'd0);
        transact(1'b1, 64'h21, 64'hFFFF);
        transact(1'b1, 64'h108, 64'hFFFF);

        // Last legal word
        transact(1'b1, 64'hF8, 64'h1234_5678_9ABC_DEF0);
        transact(1'b0, 64'hF8, 64'd0);

        // Stalled response with a request presented while busy (must be ignored)
        applyStimulus(1'b0, 64'h08, 64'd0);
        collectResponse(5, 1'b1);
        @(negedge clk);
        checkOutput("ignored_req_busy", {63'd0, busy}, 64'd0);
        checkElements("ignored_req");

        // Random mix of legal and illegal accesses
        for (int r = 0; r < 8; r++) begin
            logic [63:0] a;
            a = 64'($urandom_range(0, 33)) << 3;
            if ($urandom_range(0, 5) == 0) a = a + 64'd4;
            transact(1'($urandom_range(0, 1)), a, {$urandom, $urandom});
        end

        // Reset pulsed during WAIT of a store to word 0
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 64'h00;
        req_wdata = 64'hDEAD_BEEF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checkOutput("abort_busy_wait", {63'd0, busy}, 64'd1);
        @(negedge clk);
        reset = 1'b0;
        resetModel();
        #1;
        checkOutput("abort_busy", {63'd0, busy}, 64'd0);
        checkOutput("abort_req_ready", {63'd0, req_ready}, 64'd1);
        checkOutput("abort_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (4) begin
            @(negedge clk);
            checkOutput("abort_no_rsp", {63'd0, rsp_valid}, 64'd0);
        end
        checkOutput("abort_element1", element1, model_mem[0]);
        checkElements("after_abort");
        transact(1'b0, 64'h00, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assert_count, fail_count);
        $finish;
    end

endmodule
